// File: rtl/data_connect_pipe_pkg.sv
// Shared types for the data_connect_pipe register slice.
// State codes double as {conn_vld, buf_vld}.
package data_connect_pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY    = 2'b00,
      CONN     = 2'b10,
      CONN_BUF = 2'b11
   } pipe_state_e;

endpackage

// File: rtl/data_connect_pipe.sv
// Valid/ready skid stage: registered downstream data and upstream ready.
// conn holds the older beat, buf the newer one.
module data_connect_pipe
   import data_connect_pipe_pkg::*;
#(
   parameter int DSIZE = 8
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             clk_en,
   input  logic             from_up_vld,
   input  logic [DSIZE-1:0] from_up_data,
   output logic             to_up_ready,
   input  logic             from_down_ready,
   output logic             to_down_vld,
   output logic [DSIZE-1:0] to_down_data
);

   pipe_state_e      r_state;
   logic [DSIZE-1:0] r_conn_data;
   logic [DSIZE-1:0] r_buf_data;

   logic w_conn_vld;
   logic w_buf_vld;
   logic w_in;
   logic w_out;

   assign w_conn_vld = r_state[1];
   assign w_buf_vld  = r_state[0];

   assign to_up_ready  = clk_en & ~w_buf_vld & ~rst;
   assign to_down_vld  = clk_en & w_conn_vld;
   assign to_down_data = r_conn_data;

   assign w_in  = from_up_vld & to_up_ready;
   assign w_out = to_down_vld & from_down_ready;

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         r_state     <= EMPTY;
         r_conn_data <= '0;
         r_buf_data  <= '0;
      end else if (clk_en) begin
         unique case (r_state)
            EMPTY: begin
               if (w_in) begin
                  r_conn_data <= from_up_data;
                  r_state     <= CONN;
               end
            end
            CONN: begin
               if (w_in && w_out) begin
                  r_conn_data <= from_up_data;
               end else if (w_in) begin
                  r_buf_data <= from_up_data;
                  r_state    <= CONN_BUF;
               end else if (w_out) begin
                  r_state <= EMPTY;
               end
            end
            CONN_BUF: begin
               if (w_out) begin
                  r_conn_data <= r_buf_data;
                  r_state     <= CONN;
               end
            end
            default: r_state <= EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_data_connect_pipe.sv
// Scoreboard bench for data_connect_pipe.
// Inputs change at negedge; handshakes are sampled 1 time unit later.
module tb_data_connect_pipe;

   localparam int DSIZE = 8;

   logic             clock = 1'b0;
   logic             rst;
   logic             clk_en;
   logic             from_up_vld;
   logic [DSIZE-1:0] from_up_data;
   logic             to_up_ready;
   logic             from_down_ready;
   logic             to_down_vld;
   logic [DSIZE-1:0] to_down_data;

   int               n_chk = 0;
   int               n_fail = 0;
   int               n_out = 0;
   logic [DSIZE-1:0] sb[$];

   always #5 clock = ~clock;

   data_connect_pipe #(.DSIZE(DSIZE)) dut (
      .clock           (clock),
      .rst             (rst),
      .clk_en          (clk_en),
      .from_up_vld     (from_up_vld),
      .from_up_data    (from_up_data),
      .to_up_ready     (to_up_ready),
      .from_down_ready (from_down_ready),
      .to_down_vld     (to_down_vld),
      .to_down_data    (to_down_data)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: sample handshakes, run the scoreboard, advance to next negedge.
   task automatic cyc(output bit acc);
      logic [DSIZE-1:0] exp;
      #1;
      acc = from_up_vld && to_up_ready;
      if (acc) sb.push_back(from_up_data);
      if (to_down_vld && from_down_ready) begin
         n_out++;
         chk("sb_nonempty", 32'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            exp = sb.pop_front();
            chk("out_data", 32'(to_down_data), 32'(exp));
         end
      end
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic send(input logic [DSIZE-1:0] d);
      bit acc;
      bit done;
      done = 0;
      from_up_vld  = 1'b1;
      from_up_data = d;
      for (int k = 0; k < 20 && !done; k++) begin
         cyc(acc);
         done = acc;
      end
      chk("send_accepted", 32'(done), 1);
      from_up_vld = 1'b0;
   endtask

   task automatic idle(input int n);
      bit acc;
      from_up_vld = 1'b0;
      for (int k = 0; k < n; k++) cyc(acc);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int sent;
      int budget;
      logic r0;

      rst             = 1'b1;
      clk_en          = 1'b1;
      from_up_vld     = 1'b1;
      from_up_data    = 8'h55;
      from_down_ready = 1'b0;

      // Reset
      @(negedge clock);
      @(negedge clock);
      #1;
      chk("rst_down_vld", 32'(to_down_vld), 0);
      chk("rst_up_ready", 32'(to_up_ready), 0);
      from_up_vld = 1'b0;
      rst = 1'b0;
      #1;
      chk("rel_up_ready", 32'(to_up_ready), 1);
      chk("rel_down_data", 32'(to_down_data), 0);
      chk("rel_down_vld", 32'(to_down_vld), 0);
      @(negedge clock);

      // Streaming with 1-cycle latency
      from_down_ready = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         from_up_vld  = 1'b1;
         from_up_data = 8'(i);
         #1;
         chk("stream_ready", 32'(to_up_ready), 1);
         chk("stream_vld", 32'(to_down_vld), 32'(i > 1));
         if (i > 1) chk("stream_lat", 32'(to_down_data), 32'(i - 1));
         cyc(acc);
      end
      idle(2);
      chk("stream_count", 32'(n_out), 16);
      chk("stream_drained", 32'(sb.size()), 0);

      // Backpressure
      from_down_ready = 1'b0;
      send(8'hA1);
      #1 chk("bp_ready_a2", 32'(to_up_ready), 1);
      send(8'hA2);
      #1;
      chk("bp_ready_drop", 32'(to_up_ready), 0);
      chk("bp_hold_vld", 32'(to_down_vld), 1);
      chk("bp_hold_data", 32'(to_down_data), 32'hA1);
      from_up_vld  = 1'b1;
      from_up_data = 8'hA3;
      for (int k = 0; k < 3; k++) cyc(acc);
      chk("bp_a3_stalled", 32'(acc), 0);
      chk("bp_hold_data2", 32'(to_down_data), 32'hA1);
      from_down_ready = 1'b1;
      send(8'hA3);
      idle(4);
      chk("bp_count", 32'(n_out), 19);
      chk("bp_drained", 32'(sb.size()), 0);

      // clk_en low while holding two beats
      from_down_ready = 1'b0;
      send(8'hB1);
      send(8'hB2);
      from_down_ready = 1'b1;
      clk_en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("en_down_vld", 32'(to_down_vld), 0);
         chk("en_up_ready", 32'(to_up_ready), 0);
         cyc(acc);
      end
      chk("en_no_consume", 32'(n_out), 19);
      clk_en = 1'b1;
      #1 chk("en_resume_data", 32'(to_down_data), 32'hB1);
      idle(4);
      chk("en_count", 32'(n_out), 21);
      chk("en_drained", 32'(sb.size()), 0);

      // Random valid/ready
      sent   = 0;
      budget = 0;
      while (sent < 1000 && budget < 6000) begin
         from_up_vld     = 1'($urandom_range(0, 1));
         from_up_data    = 8'($urandom);
         from_down_ready = 1'($urandom_range(0, 1));
         #1;
         r0 = to_up_ready;
         from_down_ready = ~from_down_ready;
         #1;
         chk("ready_no_comb", 32'(to_up_ready), 32'(r0));
         from_down_ready = ~from_down_ready;
         cyc(acc);
         if (acc) sent++;
         budget++;
      end
      chk("rand_sent", 32'(sent), 1000);
      from_down_ready = 1'b1;
      idle(4);
      chk("rand_count", 32'(n_out), 1021);
      chk("rand_drained", 32'(sb.size()), 0);

      // Asynchronous mid-stream reset with two beats held
      from_down_ready = 1'b0;
      send(8'hC1);
      send(8'hC2);
      #1 chk("mr_held_vld", 32'(to_down_vld), 1);
      #1 rst = 1'b1;
      #1;
      chk("mr_async_vld", 32'(to_down_vld), 0);
      chk("mr_async_ready", 32'(to_up_ready), 0);
      chk("mr_async_data", 32'(to_down_data), 0);
      sb.delete();
      @(negedge clock);
      rst = 1'b0;
      from_down_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1 chk("mr_no_emit", 32'(to_down_vld), 0);
         cyc(acc);
      end
      chk("mr_count", 32'(n_out), 1021);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
